// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, ALU classes, mux selects.
// The JAL state exists only when MULTICYCLE_CTRL_JAL_EN is defined; its encoding is reserved here.
package mips_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StImmExec = 4'd9,
        StImmWb   = 4'd10,
        StJal     = 4'd11,
        StHalt    = 4'd12
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpJal  = 6'b000011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluAnd   = 3'b011;
    localparam logic [2:0] AluOr    = 3'b100;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMdr = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    localparam logic [1:0] AluBReg    = 2'b00;
    localparam logic [1:0] AluBFour   = 2'b01;
    localparam logic [1:0] AluBImm    = 2'b10;
    localparam logic [1:0] AluBBrOffs = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OpAndi:  return AluAnd;
            OpOri:   return AluOr;
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller side, slave = datapath side.
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       fault;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, reg_write,
               alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op, fault, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, reg_write,
               alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op, fault, state_o
    );

endinterface

// File: rtl/mc_dispatch.sv
// Next-state and opcode dispatch decode for multicycle_ctrl (purely combinational).
// MULTICYCLE_CTRL_JAL_EN enables the JAL dispatch; otherwise jal is treated as illegal.
module mc_dispatch
    import mips_pkg::*;
(
    input  state_e     i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_opcode_lat,
    input  logic       i_mem_ready,
    input  logic       i_timeout,
    output state_e     o_next_state
);

    always_comb begin
        o_next_state = i_state;
        unique case (i_state)
            StFetch: begin
                if (i_mem_ready) begin
                    o_next_state = StDecode;
                end else if (i_timeout) begin
                    o_next_state = StHalt;
                end
            end
            StDecode: begin
                case (i_opcode)
                    OpLw, OpSw:             o_next_state = StMemAddr;
                    OpR:                    o_next_state = StRExec;
                    OpBeq:                  o_next_state = StBranch;
                    OpAddi, OpAndi, OpOri:  o_next_state = StImmExec;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OpJal:                  o_next_state = StJal;
`endif
                    default:                o_next_state = StHalt;
                endcase
            end
            StMemAddr: o_next_state = (i_opcode_lat == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                if (i_mem_ready) begin
                    o_next_state = StMemWb;
                end else if (i_timeout) begin
                    o_next_state = StHalt;
                end
            end
            StMemWr: begin
                if (i_mem_ready) begin
                    o_next_state = StFetch;
                end else if (i_timeout) begin
                    o_next_state = StHalt;
                end
            end
            StRExec:   o_next_state = StRWb;
            StImmExec: o_next_state = StImmWb;
            StMemWb, StRWb, StBranch, StImmWb: o_next_state = StFetch;
`ifdef MULTICYCLE_CTRL_JAL_EN
            StJal:     o_next_state = StFetch;
`endif
            StHalt:    o_next_state = StHalt;
            // Unreachable encodings park in HALT, which also raises fault.
            default:   o_next_state = StHalt;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait timeout and sticky fault.
// MULTICYCLE_CTRL_JAL_EN adds the JAL state (link write plus jump in one cycle).
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_e     r_state;
    state_e     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_fault;
    logic [5:0] r_opcode;
    logic       w_wait_state;
    logic       w_enter_wait;
    logic       w_timeout;

    assign w_wait_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
    assign w_enter_wait = (w_next_state != r_state) &&
                          (w_next_state inside {StFetch, StMemRd, StMemWr});
    // Fires on the cycle that would be wait cycle number MEM_TIMEOUT; mem_ready=1 wins.
    assign w_timeout    = w_wait_state && !bus.mem_ready && (r_wait_cnt == TimeoutLast);

    mc_dispatch u_dispatch (
        .i_state      (r_state),
        .i_opcode     (bus.opcode),
        .i_opcode_lat (r_opcode),
        .i_mem_ready  (bus.mem_ready),
        .i_timeout    (w_timeout),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StFetch;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
            r_opcode   <= 6'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == StDecode) begin
                r_opcode <= bus.opcode;
            end
            if (w_next_state == StHalt && r_state != StHalt) begin
                r_fault <= 1'b1;
            end
            if (w_enter_wait) begin
                r_wait_cnt <= 8'd0;
            end else if (w_wait_state && !bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.reg_dst       = RegDstRt;
        bus.mem_to_reg    = MemToRegAlu;
        bus.alu_src_b     = AluBReg;
        bus.pc_source     = PcSrcAlu;
        bus.alu_op        = AluAdd;
        unique case (r_state)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = AluBFour;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            StDecode:  bus.alu_src_b = AluBBrOffs;
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = AluBImm;
            end
            StMemRd: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            StMemWr: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = MemToRegMdr;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = AluFunct;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = RegDstRd;
            end
            StBranch: begin
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PcSrcAluOut;
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = AluSub;
            end
            StImmExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = AluBImm;
                bus.alu_op    = imm_alu_op(r_opcode);
            end
            StImmWb:   bus.reg_write = 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
            StJal: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = RegDstRa;
                bus.mem_to_reg = MemToRegPc;
                bus.pc_write   = 1'b1;
                bus.pc_source  = PcSrcJump;
            end
`endif
            default: ;
        endcase
        // Reset abandons any access at once, even before the state register settles.
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.reg_write     = 1'b0;
        end
    end

    assign bus.fault   = r_fault;
    assign bus.state_o = r_state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of wait cycles on mem_ready before a bus fault (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26], sampled from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  shared memory has completed the current access.
REQ-007 SHALL have ports pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, reg_write, alu_src_a  output  1 each  datapath strobes and mux selects.
REQ-008 SHALL have ports reg_dst, mem_to_reg, alu_src_b, pc_source  output  2 each  mux selects.
REQ-009 SHALL have port alu_op  output  3  ALU control class: 000 add, 001 sub, 010 funct, 011 and, 100 or.
REQ-010 SHALL have port fault  output  1  sticky flag, set on an illegal opcode or a memory timeout.
REQ-011 SHALL have port state_o  output  4  current state, for debug.

Function
REQ-012 SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, IMM_EXEC, IMM_WB, JAL, HALT.
REQ-013 SHALL in FETCH assert mem_read with i_or_d=0 and hold FETCH until mem_ready=1; on that cycle it SHALL pulse ir_write, pc_write (pc_source=00, alu_src_a=0, alu_src_b=01, alu_op=000) and go to DECODE.
REQ-014 SHALL in DECODE compute the branch target (alu_src_a=0, alu_src_b=11, alu_op=000) and dispatch as follows:
- lw/sw -> MEM_ADDR
- R (000000) -> R_EXEC
- beq -> BRANCH
- addi/andi/ori -> IMM_EXEC
- jal -> JAL
- any other opcode -> HALT with fault set.
REQ-015 SHALL go from MEM_ADDR (alu_src_a=1, alu_src_b=10, alu_op=000) to MEM_RD for lw and to MEM_WR for sw.
REQ-016 SHALL in MEM_RD and MEM_WR assert mem_read or mem_write respectively with i_or_d=1, wait for mem_ready, then go to MEM_WB (lw) or FETCH (sw).
REQ-017 SHALL in MEM_WB assert reg_write with reg_dst=00 and mem_to_reg=01, then go to FETCH.
REQ-018 SHALL go R_EXEC (alu_src_a=1, alu_src_b=00, alu_op=010) -> R_WB (reg_write, reg_dst=01, mem_to_reg=00) -> FETCH.
REQ-019 SHALL in BRANCH assert pc_write_cond with pc_source=01, alu_src_a=1, alu_src_b=00, alu_op=001, then go to FETCH; the PC updates only when zero=1.
REQ-020 SHALL go IMM_EXEC (alu_src_a=1, alu_src_b=10, alu_op=000 for addi, 011 for andi, 100 for ori) -> IMM_WB (reg_write, reg_dst=00, mem_to_reg=00) -> FETCH; the opcode is latched in DECODE so alu_op stays stable.
REQ-021 SHALL in JAL assert reg_write (reg_dst=10, mem_to_reg=10) and pc_write (pc_source=10) in the same cycle, then go to FETCH.
REQ-022 SHALL keep an 8-bit wait counter that clears on entry to FETCH, MEM_RD or MEM_WR and increments on each cycle mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready still 0, the FSM SHALL go to HALT and set fault.
REQ-023 SHALL give precedence to mem_ready=1 over timeout when both occur on the same cycle (the access completes normally).
REQ-024 SHALL drive every strobe low and every select to 0 in any state where that strobe or select is not listed; no x values on outputs.
REQ-025 SHALL stay in HALT with all strobes low until rst.

Reset
REQ-026 SHALL on rst=1, immediately and asynchronously, set the state to FETCH, the wait counter to 0, fault to 0 and the latched opcode to 0.
REQ-027 SHALL abandon any in-flight access when rst asserts mid-access; no write strobe may be asserted while rst=1.

Configuration
REQ-028 SHALL, when macro MULTICYCLE_CTRL_JAL_EN is defined, implement the JAL state per REQ-021.
REQ-029 SHALL, when MULTICYCLE_CTRL_JAL_EN is undefined, omit the JAL state; opcode 000011 is then illegal and leads to HALT with fault=1.

Structure
REQ-030 SHALL take the opcode constants, the state enumeration, the alu_op encodings and the mux-select encodings from shared package mips_pkg.
REQ-031 SHALL place the next-state and dispatch decode in one combinational sub-module, mc_dispatch (inputs opcode and state; output next state).

Verification
REQ-032 SHALL cover lw with mem_ready tied to 1: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH in 5 cycles, with reg_write=1 and mem_to_reg=01 only in MEM_WB.
REQ-033 SHALL cover beq with zero=0 then zero=1: pc_write_cond=1 in BRANCH both times, and pc_write=0 throughout BRANCH.
REQ-034 SHALL cover FETCH with mem_ready held low for 20 cycles at MEM_TIMEOUT=15: HALT after 15 wait cycles, fault=1, all strobes 0.
REQ-035 SHALL cover opcode 111111 in DECODE: next state HALT, fault=1; rst then returns the block to FETCH with fault=0.
REQ-036 SHALL cover rst asserted during MEM_WR: mem_write drops in the same cycle, the state is FETCH, and no register write occurs.
REQ-037 SHALL cover jal in both builds: with MULTICYCLE_CTRL_JAL_EN, reg_dst=10 and pc_source=10 in JAL; without it, HALT with fault=1.
